// File: rtl/game_sprite_mover.sv
// Per-sprite position engine: holds X/Y and signed DX/DY and advances the position
// once every STROBE_PERIOD enabled clocks. Reports on-screen status and a registered pixel hit.
module game_sprite_mover #(
    parameter int X_WIDTH       = 10,
    parameter int Y_WIDTH       = 10,
    parameter int DX_WIDTH      = 3,
    parameter int DY_WIDTH      = 3,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int SPRITE_WIDTH  = 8,
    parameter int SPRITE_HEIGHT = 8,
    parameter int STROBE_PERIOD = 250000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       write_xy,
    input  logic                       write_dxy,
    input  logic                       enable_update,
    input  logic [X_WIDTH-1:0]         x_in,
    input  logic [Y_WIDTH-1:0]         y_in,
    input  logic signed [DX_WIDTH-1:0] dx_in,
    input  logic signed [DY_WIDTH-1:0] dy_in,
    input  logic [X_WIDTH-1:0]         pixel_x,
    input  logic [Y_WIDTH-1:0]         pixel_y,
    output logic [X_WIDTH-1:0]         x,
    output logic [Y_WIDTH-1:0]         y,
    output logic                       within_screen,
    output logic                       pixel_hit,
    output logic                       update_strobe
);

    localparam int CNT_W = (STROBE_PERIOD > 1) ? $clog2(STROBE_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STROBE_PERIOD - 1);
    localparam int XE_W = X_WIDTH + 1;
    localparam int YE_W = Y_WIDTH + 1;

    logic [CNT_W-1:0]         r_cnt;
    logic [X_WIDTH-1:0]       r_x;
    logic [Y_WIDTH-1:0]       r_y;
    logic signed [DX_WIDTH-1:0] r_dx;
    logic signed [DY_WIDTH-1:0] r_dy;
    logic                     r_update_strobe_p1;
    logic                     r_pixel_hit_p1;

    logic                     w_tick;
    logic [XE_W-1:0]          w_x_end;
    logic [YE_W-1:0]          w_y_end;
    logic                     w_hit_x;
    logic                     w_hit_y;

    // Position plus sign-extended velocity, wrapping modulo the register width.
    function automatic logic [X_WIDTH-1:0] step_x(input logic [X_WIDTH-1:0] pos,
                                                   input logic signed [DX_WIDTH-1:0] vel);
        logic signed [X_WIDTH-1:0] v_ext;
        v_ext = X_WIDTH'(vel);
        return pos + $unsigned(v_ext);
    endfunction

    function automatic logic [Y_WIDTH-1:0] step_y(input logic [Y_WIDTH-1:0] pos,
                                                   input logic signed [DY_WIDTH-1:0] vel);
        logic signed [Y_WIDTH-1:0] v_ext;
        v_ext = Y_WIDTH'(vel);
        return pos + $unsigned(v_ext);
    endfunction

    assign w_tick = enable_update && (r_cnt == CNT_LAST) && !write_xy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (write_xy) begin
            r_cnt <= '0;
        end else if (enable_update) begin
            r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    // Advance reads the velocity registers before a same-cycle write_dxy lands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x                <= '0;
            r_y                <= '0;
            r_dx               <= '0;
            r_dy               <= '0;
            r_update_strobe_p1 <= 1'b0;
        end else begin
            if (write_xy) begin
                r_x <= x_in;
                r_y <= y_in;
            end else if (w_tick) begin
                r_x <= step_x(r_x, r_dx);
                r_y <= step_y(r_y, r_dy);
            end
            if (write_dxy) begin
                r_dx <= dx_in;
                r_dy <= dy_in;
            end
            r_update_strobe_p1 <= w_tick;
        end
    end

    // Extra bit keeps the far edge from aliasing back to the left/top of the screen.
    assign w_x_end = {1'b0, r_x} + XE_W'(SPRITE_WIDTH);
    assign w_y_end = {1'b0, r_y} + YE_W'(SPRITE_HEIGHT);

    assign within_screen = (w_x_end <= XE_W'(SCREEN_WIDTH)) && (w_y_end <= YE_W'(SCREEN_HEIGHT));

    assign w_hit_x = (pixel_x >= r_x) && ({1'b0, pixel_x} < w_x_end);
    assign w_hit_y = (pixel_y >= r_y) && ({1'b0, pixel_y} < w_y_end);

    // Stage p0 -> p1: pixel hit registered for the display mixer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pixel_hit_p1 <= 1'b0;
        end else begin
            r_pixel_hit_p1 <= w_hit_x && w_hit_y;
        end
    end

    assign x             = r_x;
    assign y             = r_y;
    assign pixel_hit     = r_pixel_hit_p1;
    assign update_strobe = r_update_strobe_p1;

endmodule

// File: tb/tb_game_sprite_mover.sv
// Vector-table and scoreboard bench for game_sprite_mover with STROBE_PERIOD=4.
module tb_game_sprite_mover;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       write_xy = 1'b0;
    logic       write_dxy = 1'b0;
    logic       enable_update = 1'b0;
    logic [9:0] x_in = '0;
    logic [9:0] y_in = '0;
    logic [2:0] dx_in = '0;
    logic [2:0] dy_in = '0;
    logic [9:0] pixel_x = 10'd1000;
    logic [9:0] pixel_y = 10'd1000;
    logic [9:0] x;
    logic [9:0] y;
    logic       within_screen;
    logic       pixel_hit;
    logic       update_strobe;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    game_sprite_mover #(.STROBE_PERIOD(4)) dut (
        .clk(clk), .reset(reset),
        .write_xy(write_xy), .write_dxy(write_dxy), .enable_update(enable_update),
        .x_in(x_in), .y_in(y_in), .dx_in(dx_in), .dy_in(dy_in),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .x(x), .y(y), .within_screen(within_screen),
        .pixel_hit(pixel_hit), .update_strobe(update_strobe)
    );

    typedef struct {
        string      tag;
        logic       wxy, wdxy, en;
        logic [9:0] xi, yi;
        logic [2:0] dxi, dyi;
        logic [9:0] px, py;
        logic [9:0] ex, ey;
        logic       ews, est, ehit;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    function automatic void add(string tag, logic wxy, logic wdxy, logic en,
                                logic [9:0] xi, logic [9:0] yi, logic [2:0] dxi, logic [2:0] dyi,
                                logic [9:0] ex, logic [9:0] ey, logic ews, logic est);
        vecs.push_back('{tag, wxy, wdxy, en, xi, yi, dxi, dyi, 10'd1000, 10'd1000,
                         ex, ey, ews, est, 1'b0});
    endfunction

    function automatic void hold(string tag, int n, logic en, logic [9:0] ex, logic [9:0] ey,
                                 logic ews);
        for (int k = 0; k < n; k++) add(tag, 0, 0, en, 0, 0, 0, 0, ex, ey, ews, 0);
    endfunction

    function automatic void pix(string tag, logic [9:0] px, logic [9:0] py, logic [9:0] ex,
                                logic [9:0] ey, logic ehit);
        vecs.push_back('{tag, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 3'd0, 3'd0, px, py,
                         ex, ey, 1'b1, 1'b0, ehit});
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        vec_t e;

        // Load then 12 enabled clocks: strobes on clocks 4, 8, 12.
        add("load_xy",  1, 0, 0, 100, 50, 0, 0, 100, 50, 1, 0);
        add("load_dxy", 0, 1, 0, 0, 0, 3'd1, 3'b111, 100, 50, 1, 0);
        hold("run_a", 3, 1, 100, 50, 1);
        add("tick1",    0, 0, 1, 0, 0, 0, 0, 101, 49, 1, 1);
        hold("run_b", 3, 1, 101, 49, 1);
        add("tick2",    0, 0, 1, 0, 0, 0, 0, 102, 48, 1, 1);
        hold("run_c", 3, 1, 102, 48, 1);
        add("tick3",    0, 0, 1, 0, 0, 0, 0, 103, 47, 1, 1);
        // Underflow wraps to 1023 and leaves the screen.
        add("uf_load",  1, 1, 0, 2, 50, 3'b101, 0, 2, 50, 1, 0);
        hold("uf_run", 3, 1, 2, 50, 1);
        add("uf_tick",  0, 0, 1, 0, 0, 0, 0, 1023, 50, 0, 1);
        // Right edge: 632 still fits, 633 does not.
        add("re_load",  1, 1, 0, 631, 50, 3'd1, 0, 631, 50, 1, 0);
        hold("re_run1", 3, 1, 631, 50, 1);
        add("re_tick1", 0, 0, 1, 0, 0, 0, 0, 632, 50, 1, 1);
        hold("re_run2", 3, 1, 632, 50, 1);
        add("re_tick2", 0, 0, 1, 0, 0, 0, 0, 633, 50, 0, 1);
        // write_xy on the tick cycle wins and restarts the count.
        add("pr_load",  1, 1, 0, 5, 50, 3'd1, 0, 5, 50, 1, 0);
        hold("pr_run1", 3, 1, 5, 50, 1);
        add("pr_wxy",   1, 0, 1, 10, 50, 0, 0, 10, 50, 1, 0);
        hold("pr_run2", 3, 1, 10, 50, 1);
        add("pr_tick",  0, 0, 1, 0, 0, 0, 0, 11, 50, 1, 1);
        // write_xy mid-count clears the counter.
        hold("mc_run1", 2, 1, 11, 50, 1);
        add("mc_wxy",   1, 0, 1, 20, 50, 0, 0, 20, 50, 1, 0);
        hold("mc_run2", 3, 1, 20, 50, 1);
        add("mc_tick",  0, 0, 1, 0, 0, 0, 0, 21, 50, 1, 1);
        // write_dxy on a tick cycle: this advance uses the old dx.
        hold("dx_run1", 3, 1, 21, 50, 1);
        add("dx_tick1", 0, 1, 1, 0, 0, 3'd3, 0, 22, 50, 1, 1);
        hold("dx_run2", 3, 1, 22, 50, 1);
        add("dx_tick2", 0, 0, 1, 0, 0, 0, 0, 25, 50, 1, 1);
        // Pixel hit window for a sprite at 20,30.
        add("ph_load",  1, 0, 0, 20, 30, 0, 0, 20, 30, 1, 0);
        pix("ph_in_far",  27, 37, 20, 30, 1);
        pix("ph_x_out",   28, 37, 20, 30, 0);
        pix("ph_left",    19, 30, 20, 30, 0);
        pix("ph_corner",  20, 30, 20, 30, 1);
        pix("ph_y_out",   27, 38, 20, 30, 0);
        // Disabling enable freezes the counter without losing phase.
        add("fz_load",  1, 0, 0, 100, 100, 0, 0, 100, 100, 1, 0);
        hold("fz_run1", 2, 1, 100, 100, 1);
        hold("fz_off",  5, 0, 100, 100, 1);
        hold("fz_run2", 1, 1, 100, 100, 1);
        add("fz_tick",  0, 0, 1, 0, 0, 0, 0, 103, 100, 1, 1);

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_within", within_screen, 1);
        check("rst_hit", pixel_hit, 0);
        check("rst_strobe", update_strobe, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            write_xy = vecs[i].wxy;
            write_dxy = vecs[i].wdxy;
            enable_update = vecs[i].en;
            x_in = vecs[i].xi;
            y_in = vecs[i].yi;
            dx_in = vecs[i].dxi;
            dy_in = vecs[i].dyi;
            pixel_x = vecs[i].px;
            pixel_y = vecs[i].py;
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check({e.tag, "_x"}, x, e.ex);
            check({e.tag, "_y"}, y, e.ey);
            check({e.tag, "_within"}, within_screen, e.ews);
            check({e.tag, "_strobe"}, update_strobe, e.est);
            check({e.tag, "_hit"}, pixel_hit, e.ehit);
        end
        check("sb_empty", sb.size(), 0);

        // Asynchronous reset right after an advance clears everything before the next edge.
        @(negedge clk);
        write_xy = 1'b1;
        write_dxy = 1'b1;
        enable_update = 1'b0;
        x_in = 10'd300;
        y_in = 10'd200;
        dx_in = 3'd1;
        dy_in = 3'd1;
        pixel_x = 10'd303;
        pixel_y = 10'd203;
        @(negedge clk);
        write_xy = 1'b0;
        write_dxy = 1'b0;
        enable_update = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("mid_x", x, 301);
        check("mid_strobe", update_strobe, 1);
        check("mid_hit", pixel_hit, 1);
        #1;
        reset = 1'b1;
        #1;
        check("arst_x", x, 0);
        check("arst_y", y, 0);
        check("arst_within", within_screen, 1);
        check("arst_strobe", update_strobe, 0);
        check("arst_hit", pixel_hit, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_x", x, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
